// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE constants used by the sponge pipeline stages.
package keccak_pkg;

    // Rate of each SHAKE variant, in bits.
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    // Operation mode encodings carried alongside each squeezed block.
    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

    // Words per squeezed block when the output stream is 64 bits wide.
    localparam int SQZ_WORDS_128 = RATE_SHAKE128 / 64;
    localparam int SQZ_WORDS_256 = RATE_SHAKE256 / 64;

    // Rate in bits for a mode vector; zero flags an unsupported mode.
    function automatic logic [31:0] mode_rate_bits(input logic [1:0] mode);
        logic [31:0] rate;
        rate = '0;
        if (mode == SHAKE128_MODE_VEC) begin
            rate = 32'(RATE_SHAKE128);
        end else if (mode == SHAKE256_MODE_VEC) begin
            rate = 32'(RATE_SHAKE256);
        end
        return rate;
    endfunction

endpackage

// File: rtl/squeeze_output_tail_mask.sv
// Tail mask for truncating stages: turns the number of output bits still owed
// into a keep-mask over the MSB-first word plus a count of meaningful bits.
module tail_mask #(
    parameter int OUT_WIDTH = 64
) (
    input  logic [31:0]                  i_rem_bits,
    output logic [OUT_WIDTH-1:0]         o_mask,
    output logic [$clog2(OUT_WIDTH):0]   o_valid_bits
);

    localparam int VB_W = $clog2(OUT_WIDTH) + 1;

    // Full word unless fewer than OUT_WIDTH bits remain; then keep only the top rem bits.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_mask       = '1;
        o_valid_bits = VB_W'(OUT_WIDTH);
        if (i_rem_bits < 32'(OUT_WIDTH)) begin
            o_valid_bits = i_rem_bits[VB_W-1:0];
            o_mask       = ~({OUT_WIDTH{1'b1}} >> i_rem_bits[VB_W-1:0]);
        end
    end

endmodule

// File: rtl/squeeze_output_stage.sv
// Final SHAKE stage: serialises each squeezed rate block into OUT_WIDTH-bit
// words on a valid/ready stream and truncates to the requested output length.
module squeeze_output_stage
    import keccak_pkg::*;
#(
    parameter int OUT_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        block_valid,
    output logic                        block_ready,
    input  logic [RATE_SHAKE128-1:0]    rate_block,
    input  logic [1:0]                  operation_mode,
    input  logic [31:0]                 output_size,
    output logic [OUT_WIDTH-1:0]        dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        dout_last,
    output logic [$clog2(OUT_WIDTH):0]  dout_valid_bits,
    output logic                        mode_error
);

    localparam int LOG_W = $clog2(OUT_WIDTH);
    localparam int VB_W  = LOG_W + 1;

    localparam logic [5:0] WORDS_128 = 6'(RATE_SHAKE128 / OUT_WIDTH);
    localparam logic [5:0] WORDS_256 = 6'(RATE_SHAKE256 / OUT_WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]               r_state;
    logic [RATE_SHAKE128-1:0] r_buf;
    logic [5:0]               r_words;
    logic [5:0]               r_cnt;
    logic [31:0]              r_rem;
    logic                     r_final;
    logic                     r_mode_error;

    logic                     w_send;
    logic                     w_last_word;
    logic                     w_accept;
    logic                     w_word_hs;
    logic                     w_mode_ok;
    logic [5:0]               w_rate_words;
    logic [5:0]               w_words;
    logic [31:0]              w_rate_bits;
    logic [32:0]              w_ceil;
    logic                     w_final;
    logic [OUT_WIDTH-1:0]     w_mask;
    logic [VB_W-1:0]          w_vbits;

    // Decode the incoming mode into words per block and rate in bits.
    always_comb begin
        w_mode_ok    = 1'b0;
        w_rate_words = '0;
        case (operation_mode)
            SHAKE128_MODE_VEC: begin
                w_mode_ok    = 1'b1;
                w_rate_words = WORDS_128;
            end
            SHAKE256_MODE_VEC: begin
                w_mode_ok    = 1'b1;
                w_rate_words = WORDS_256;
            end
            default: begin
                w_mode_ok    = 1'b0;
                w_rate_words = '0;
            end
        endcase
    end

    assign w_rate_bits = mode_rate_bits(operation_mode);

    // 33-bit intermediate so sizes near 2^32 do not wrap when rounding up.
    assign w_ceil  = ({1'b0, output_size} + 33'(OUT_WIDTH - 1)) >> LOG_W;
    assign w_words = (w_ceil < {27'd0, w_rate_words}) ? w_ceil[5:0] : w_rate_words;
    assign w_final = (output_size <= w_rate_bits);

    assign w_send      = (r_state == ST_SEND);
    assign w_last_word = (r_cnt == (r_words - 6'd1));
    assign w_word_hs   = w_send && dout_ready;
    assign block_ready = !w_send || (w_last_word && dout_ready);
    assign w_accept    = block_valid && block_ready;

    tail_mask #(
        .OUT_WIDTH    (OUT_WIDTH)
    ) u_tail_mask (
        .i_rem_bits   (r_rem),
        .o_mask       (w_mask),
        .o_valid_bits (w_vbits)
    );

    assign dout_valid      = w_send;
    assign dout            = w_send ? (r_buf[RATE_SHAKE128-1 -: OUT_WIDTH] & w_mask) : '0;
    assign dout_valid_bits = w_send ? w_vbits : '0;
    assign dout_last       = w_send && r_final && w_last_word;
    assign mode_error      = r_mode_error;

    // Block control: latch a new block on acceptance, advance one word per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_words <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_final <= 1'b0;
        end else if (w_accept) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= (w_words != 6'd0) ? ST_SEND : ST_IDLE;
            r_words <= w_words;
            r_cnt   <= '0;
            r_rem   <= output_size;
            r_final <= w_final;
        end else if (w_word_hs) begin
            r_cnt <= r_cnt + 6'd1;
            r_rem <= (r_rem > 32'(OUT_WIDTH)) ? (r_rem - 32'(OUT_WIDTH)) : '0;
            if (w_last_word) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Block buffer: load on acceptance, shift the sent word out of the top on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the wide buffer is cleared on reset so no stale block data survives it.
            r_buf <= '0;
        end else if (w_accept) begin
            r_buf <= rate_block;
        end else if (w_word_hs) begin
            r_buf <= r_buf << OUT_WIDTH;
        end
    end

    // Sticky flag raised when a block with an unsupported mode is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_error <= 1'b0;
        end else if (w_accept && !w_mode_ok) begin
            r_mode_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_squeeze_output_stage.sv
// Self-checking bench for squeeze_output_stage (OUT_WIDTH = 64).
module tb_squeeze_output_stage;
    import keccak_pkg::*;

    localparam int OW = 64;

    typedef struct {
        logic [63:0] data;
        int          vbits;
        bit          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          block_valid;
    logic          block_ready;
    logic [1343:0] rate_block;
    logic [1:0]    operation_mode;
    logic [31:0]   output_size;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic [6:0]    dout_valid_bits;
    logic          mode_error;

    squeeze_output_stage #(.OUT_WIDTH(OW)) dut (
        .clk             (clk),
        .rst             (rst),
        .block_valid     (block_valid),
        .block_ready     (block_ready),
        .rate_block      (rate_block),
        .operation_mode  (operation_mode),
        .output_size     (output_size),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .dout_last       (dout_last),
        .dout_valid_bits (dout_valid_bits),
        .mode_error      (mode_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    exp_t exp_q[$];
    bit   exp_err = 1'b0;

    // Expand one accepted block into the words the stream must carry.
    function automatic void model_push(input logic [1343:0] blk, input logic [1:0] mode,
                                       input logic [31:0] size);
        longint rate;
        longint nw;
        longint rem;
        bit     fin;
        exp_t   e;
        rate = (mode == SHAKE128_MODE_VEC) ? 1344 : (mode == SHAKE256_MODE_VEC) ? 1088 : 0;
        if (rate == 0) exp_err = 1'b1;
        nw = (longint'(size) + 63) / 64;
        if (nw > rate / 64) nw = rate / 64;
        fin = (longint'(size) <= rate);
        for (int i = 0; i < nw; i++) begin
            rem = longint'(size) - 64 * i;
            if (rem < 0) rem = 0;
            e.vbits = (rem < 64) ? int'(rem) : 64;
            e.data  = blk[1343 - i*64 -: 64];
            for (int b = 0; b < 64 - e.vbits; b++) e.data[b] = 1'b0;
            e.last  = fin && (i == nw - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [1343:0] make_block(input logic [15:0] seed);
        logic [1343:0] b;
        b = '0;
        for (int i = 0; i < 21; i++) b[1343 - i*64 -: 64] = {32'h01234567, seed, 8'hCD, 8'(i)};
        return b;
    endfunction

    // ---------------- per-test statistics ----------------
    int          cyc = 0;
    int          hs_count, last_cnt, last_pos, valid_cnt, stall_cnt, first_cyc, last_cyc;
    logic [63:0] cap_data [64];
    int          cap_vb [64];

    bit          prev_stall = 1'b0;
    logic [63:0] prev_dout;
    logic        prev_last;
    logic [6:0]  prev_vbits;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_err    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_t e;
            check("dout_valid", 64'(dout_valid), 64'(exp_q.size() != 0));
            check("mode_error", 64'(mode_error), 64'(exp_err));
            if (!dout_valid) check("dout_last_idle", 64'(dout_last), 64'd0);
            if (prev_stall) begin
                check("hold_dout", dout, prev_dout);
                check("hold_last", 64'(dout_last), 64'(prev_last));
                check("hold_vbits", 64'(dout_valid_bits), 64'(prev_vbits));
            end
            if (dout_valid) valid_cnt++;
            if (dout_valid && dout_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout", dout, e.data);
                check("dout_valid_bits", 64'(dout_valid_bits), 64'(e.vbits));
                check("dout_last", 64'(dout_last), 64'(e.last));
                if (hs_count < 64) begin
                    cap_data[hs_count] = dout;
                    cap_vb[hs_count]   = int'(dout_valid_bits);
                end
                hs_count++;
                if (hs_count == 1) first_cyc = cyc;
                last_cyc = cyc;
                if (dout_last) begin
                    last_cnt++;
                    last_pos = hs_count;
                end
            end
            if (dout_valid && !dout_ready) begin
                check("block_ready_stall", 64'(block_ready), 64'd0);
                stall_cnt++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
            prev_vbits = dout_valid_bits;
            if (block_valid && block_ready) model_push(rate_block, operation_mode, output_size);
        end
    end

    // Pseudo-random backpressure when enabled.
    bit bp_en = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) dout_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        hs_count = 0; last_cnt = 0; last_pos = 0; valid_cnt = 0;
        stall_cnt = 0; first_cyc = 0; last_cyc = 0;
    endtask

    task automatic send_block(input logic [1343:0] blk, input logic [1:0] mode, input logic [31:0] size);
        bit ok;
        ok             = 1'b0;
        block_valid    = 1'b1;
        rate_block     = blk;
        operation_mode = mode;
        output_size    = size;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (block_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        block_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !dout_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Watchdog in case something stalls outside the bounded loops.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b1; block_valid = 1'b0; rate_block = '0; operation_mode = 2'b00;
        output_size = '0; dout_ready = 1'b1;
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_block_ready", 64'(block_ready), 64'd1);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_dout_last", 64'(dout_last), 64'd0);
        check("rst_valid_bits", 64'(dout_valid_bits), 64'd0);
        check("rst_mode_error", 64'(mode_error), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // SHAKE128, 256 bits -> 4 full words, last on word 4.
        clear_stats();
        send_block(make_block(16'h89AB), SHAKE128_MODE_VEC, 32'd256);
        drain();
        check("t1_words", 64'(hs_count), 64'd4);
        check("t1_last_cnt", 64'(last_cnt), 64'd1);
        check("t1_last_pos", 64'(last_pos), 64'd4);
        check("t1_word0", cap_data[0], 64'h0123_4567_89AB_CD00);
        check("t1_word3", cap_data[3], 64'h0123_4567_89AB_CD03);
        check("t1_vbits3", 64'(cap_vb[3]), 64'd64);

        // SHAKE256, 2176 bits over two blocks -> 34 contiguous words.
        clear_stats();
        send_block(make_block(16'h1111), SHAKE256_MODE_VEC, 32'd2176);
        send_block(make_block(16'h2222), SHAKE256_MODE_VEC, 32'd1088);
        drain();
        check("t2_words", 64'(hs_count), 64'd34);
        check("t2_last_cnt", 64'(last_cnt), 64'd1);
        check("t2_last_pos", 64'(last_pos), 64'd34);
        check("t2_span", 64'(last_cyc - first_cyc), 64'd33);
        check("t2_word17", cap_data[17], 64'h0123_4567_2222_CD00);

        // SHAKE128, 100 bits -> 2 words, second carries 36 bits.
        clear_stats();
        send_block(make_block(16'h89AB), SHAKE128_MODE_VEC, 32'd100);
        drain();
        check("t3_words", 64'(hs_count), 64'd2);
        check("t3_vbits1", 64'(cap_vb[1]), 64'd36);
        check("t3_word1", cap_data[1], 64'h0123_4567_8000_0000);
        check("t3_last_pos", 64'(last_pos), 64'd2);

        // Backpressure over a full SHAKE128 block.
        clear_stats();
        bp_en = 1'b1;
        send_block(make_block(16'h5A5A), SHAKE128_MODE_VEC, 32'd1344);
        drain();
        bp_en = 1'b0;
        dout_ready = 1'b1;
        check("bp_words", 64'(hs_count), 64'd21);
        check("bp_last_pos", 64'(last_pos), 64'd21);
        check("bp_stalled", 64'(stall_cnt != 0), 64'd1);

        // Reset after word 5 of 21.
        clear_stats();
        send_block(make_block(16'h7777), SHAKE128_MODE_VEC, 32'd1344);
        begin
            bit ok;
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(posedge clk);
                if (hs_count >= 5) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("rst_wait_timeout", 64'(ok), 64'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(dout_valid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(block_ready), 64'd1);
        @(posedge clk);
        #1;
        clear_stats();
        send_block(make_block(16'h3C3C), SHAKE128_MODE_VEC, 32'd128);
        drain();
        check("rst_new_words", 64'(hs_count), 64'd2);
        check("rst_new_word0", cap_data[0], 64'h0123_4567_3C3C_CD00);

        // Size 0 with a valid mode: consumed silently, no error.
        clear_stats();
        send_block(make_block(16'h4444), SHAKE256_MODE_VEC, 32'd0);
        repeat (3) @(negedge clk);
        check("zero_valid_cnt", 64'(valid_cnt), 64'd0);
        check("zero_mode_error", 64'(mode_error), 64'd0);
        @(posedge clk);
        #1;

        // Unsupported mode: consumed, no words, sticky error until reset.
        send_block(make_block(16'h4444), 2'b11, 32'd256);
        repeat (3) @(negedge clk);
        check("bad_valid_cnt", 64'(valid_cnt), 64'd0);
        check("bad_mode_error", 64'(mode_error), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("bad_mode_error_rst", 64'(mode_error), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
